// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the MIPS32 multicycle main control.
// MC_ADDI_EN adds the ADDI_EX/ADDI_WB states.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
`ifdef MC_ADDI_EN
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11
`else
    S_JUMP      = 4'd9
`endif
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_timeout;
  } ctrl_t;

  // States that stall on the memory handshake
  function automatic logic is_wait_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_READ) ||
           (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mc_main_control_if.sv
// Control bundle between the main control FSM and the datapath.
// master = controller, slave = datapath side.
interface mc_main_control_if #(
  parameter int STATE_W = 4
);

  logic [5:0]         opcode;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_source;
  logic               illegal_op;
  logic               mem_timeout;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d,
    output mem_read, mem_write, ir_write,
    output mem_to_reg, reg_dst, reg_write,
    output alu_src_a, alu_src_b, alu_op,
    output pc_source, illegal_op, mem_timeout,
    output state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d,
    input  mem_read, mem_write, ir_write,
    input  mem_to_reg, reg_dst, reg_write,
    input  alu_src_a, alu_src_b, alu_op,
    input  pc_source, illegal_op, mem_timeout,
    input  state
  );

endinterface

// File: rtl/mc_mem_watchdog.sv
// Memory wait counter; pulses o_timeout after MEM_TIMEOUT
// consecutive not-ready cycles (MEM_TIMEOUT=0 disables it).
module mc_mem_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_wait,
  input  logic i_mem_ready,
  output logic o_timeout
);

  localparam int CW =
    (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_stall;

  assign w_stall = i_wait & ~i_mem_ready;

  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      assign o_timeout = 1'b0;
    end else begin : g_on
      assign o_timeout = w_stall & (r_cnt == LIMIT);
    end
  endgenerate

  // Leaving a wait state always goes through a ready or
  // timeout cycle, so clearing here covers every entry.
  always_ff @(posedge clk) begin
    if (reset || !w_stall || o_timeout)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/mc_main_control.sv
// MIPS32 multicycle main control FSM with memory watchdog.
// Define MC_ADDI_EN to execute addi (opcode 001000).
module mc_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int STATE_W     = 4
) (
  input logic               clk,
  input logic               reset,
  mc_main_control_if.master bus
);

  state_e r_state;
  state_e w_next;
  ctrl_t  w_ctrl;
  ctrl_t  w_out;
  logic   w_wait;
  logic   w_timeout;
  logic   w_op_mem;
  logic   w_op_r;
  logic   w_op_beq;
  logic   w_op_j;
`ifdef MC_ADDI_EN
  logic   w_op_addi;
`endif

  assign w_op_mem = (bus.opcode == OP_LW) ||
                    (bus.opcode == OP_SW);
  assign w_op_r   = (bus.opcode == OP_RTYPE);
  assign w_op_beq = (bus.opcode == OP_BEQ);
  assign w_op_j   = (bus.opcode == OP_J);
`ifdef MC_ADDI_EN
  assign w_op_addi = (bus.opcode == OP_ADDI);
`endif

  assign w_wait = is_wait_state(r_state);

  mc_mem_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wdog (
    .clk         (clk),
    .reset       (reset),
    .i_wait      (w_wait),
    .i_mem_ready (bus.mem_ready),
    .o_timeout   (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_FETCH;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_ctrl = '0;
    unique case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_ctrl.pc_source = PCSRC_ALU;
        w_ctrl.ir_write  = bus.mem_ready;
        w_ctrl.pc_write  = bus.mem_ready;
        if (bus.mem_ready)
          w_next = S_DECODE;
      end
      S_DECODE: begin
        w_ctrl.alu_src_b = SRCB_IMM_SH;
        w_ctrl.alu_op    = ALUOP_ADD;
        unique case (1'b1)
          w_op_mem: w_next = S_MEM_ADDR;
          w_op_r:   w_next = S_EXECUTE;
          w_op_beq: w_next = S_BRANCH;
          w_op_j:   w_next = S_JUMP;
`ifdef MC_ADDI_EN
          w_op_addi: w_next = S_ADDI_EX;
`endif
          default: begin
            w_next            = S_FETCH;
            w_ctrl.illegal_op = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_next = (bus.opcode == OP_SW) ? S_MEM_WRITE
                                       : S_MEM_READ;
      end
      S_MEM_READ: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
        if (bus.mem_ready)
          w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_next = S_FETCH;
      end
      S_MEM_WRITE: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.i_or_d    = 1'b1;
        if (bus.mem_ready)
          w_next = S_FETCH;
      end
      S_EXECUTE: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_REG;
        w_ctrl.alu_op    = ALUOP_FUNCT;
        w_next = S_R_WB;
      end
      S_R_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = SRCB_REG;
        w_ctrl.alu_op        = ALUOP_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = PCSRC_ALUOUT;
        w_next = S_FETCH;
      end
      S_JUMP: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCSRC_JUMP;
        w_next = S_FETCH;
      end
`ifdef MC_ADDI_EN
      S_ADDI_EX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_next = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_next = S_FETCH;
      end
`endif
      default: w_next = S_FETCH;
    endcase
    // Abort a stalled access and restart from fetch
    if (w_timeout) begin
      w_next             = S_FETCH;
      w_ctrl.mem_timeout = 1'b1;
    end
  end

  assign w_out = reset ? '0 : w_ctrl;

  assign bus.pc_write      = w_out.pc_write;
  assign bus.pc_write_cond = w_out.pc_write_cond;
  assign bus.i_or_d        = w_out.i_or_d;
  assign bus.mem_read      = w_out.mem_read;
  assign bus.mem_write     = w_out.mem_write;
  assign bus.ir_write      = w_out.ir_write;
  assign bus.mem_to_reg    = w_out.mem_to_reg;
  assign bus.reg_dst       = w_out.reg_dst;
  assign bus.reg_write     = w_out.reg_write;
  assign bus.alu_src_a     = w_out.alu_src_a;
  assign bus.alu_src_b     = w_out.alu_src_b;
  assign bus.alu_op        = w_out.alu_op;
  assign bus.pc_source     = w_out.pc_source;
  assign bus.illegal_op    = w_out.illegal_op;
  assign bus.mem_timeout   = w_out.mem_timeout;
  assign bus.state =
    reset ? '0 : STATE_W'(r_state);

endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for mc_main_control: instruction-level
// reference model with random opcodes, stalls and resets.
module tb_mc_main_control;

  localparam int MT = 4;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       ill;
    logic       tmo;
  } outs_t;

  typedef struct packed {
    outs_t      o;
    logic [3:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_main_control_if #(.STATE_W(4)) bus ();

  mc_main_control #(
    .MEM_TIMEOUT (MT),
    .STATE_W     (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Model: current phase, remaining phases of the instruction
  int m_cur = 0;
  int m_plan[$];
  int m_wcnt = 0;

  function automatic bit addi_en();
`ifdef MC_ADDI_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic outs_t phase_outs(int s);
    outs_t o;
    o = '0;
    case (s)
      0:  begin o.mrd = 1; o.srcb = 2'b01; end
      1:  o.srcb = 2'b11;
      2:  begin o.srca = 1; o.srcb = 2'b10; end
      3:  begin o.mrd = 1; o.iord = 1; end
      4:  begin o.rw = 1; o.m2r = 1; end
      5:  begin o.mwr = 1; o.iord = 1; end
      6:  begin o.srca = 1; o.aluop = 2'b10; end
      7:  begin o.rw = 1; o.rdst = 1; end
      8:  begin
        o.srca = 1; o.aluop = 2'b01;
        o.pcwc = 1; o.pcsrc = 2'b01;
      end
      9:  begin o.pcw = 1; o.pcsrc = 2'b10; end
      10: begin o.srca = 1; o.srcb = 2'b10; end
      11: o.rw = 1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic void route(logic [5:0] op);
    m_plan.delete();
    case (op)
      6'b100011: m_plan = '{2, 3, 4};
      6'b101011: m_plan = '{2, 5};
      6'b000000: m_plan = '{6, 7};
      6'b000100: m_plan = '{8};
      6'b000010: m_plan = '{9};
      6'b001000: if (addi_en()) m_plan = '{10, 11};
      default: ;
    endcase
  endfunction

  function automatic int pick_op();
    case ($urandom_range(0, 7))
      0: return 6'b000000;
      1: return 6'b100011;
      2: return 6'b101011;
      3: return 6'b000100;
      4: return 6'b000010;
      5: return 6'b001000;
      default: return int'($urandom_range(0, 63));
    endcase
  endfunction

  function automatic int pick_stall();
    if ($urandom_range(0, 9) < 6) return 0;
    return int'($urandom_range(1, 6));
  endfunction

  task automatic step(input bit rst, input bit rdy,
                      input int fop);
    exp_t e;
    bit   waiting;
    bit   tmo;
    @(posedge clk);
    #1;
    if (fop >= 0) bus.opcode = 6'(fop);
    else if (!rst && m_cur == 1) bus.opcode = 6'(pick_op());
    reset = rst;
    bus.mem_ready = rdy;
    e = '0;
    if (rst) begin
      q.push_back(e);
      m_cur = 0;
      m_plan.delete();
      m_wcnt = 0;
      return;
    end
    e.o  = phase_outs(m_cur);
    e.st = 4'(m_cur);
    if (m_cur == 0) begin
      e.o.pcw = rdy;
      e.o.irw = rdy;
    end
    waiting = (m_cur == 0) || (m_cur == 3) || (m_cur == 5);
    tmo = waiting && !rdy && (MT != 0) && (m_wcnt == MT - 1);
    e.o.tmo = tmo;
    if (m_cur == 1) begin
      route(bus.opcode);
      e.o.ill = (m_plan.size() == 0);
    end
    q.push_back(e);
    if (waiting && !rdy) begin
      if (tmo) begin
        m_cur = 0;
        m_plan.delete();
        m_wcnt = 0;
      end else begin
        m_wcnt++;
      end
    end else begin
      m_wcnt = 0;
      if (m_cur == 0) m_cur = 1;
      else if (m_plan.size() > 0) m_cur = m_plan.pop_front();
      else m_cur = 0;
    end
  endtask

  // One instruction: fetch stalls, decode, then run to FETCH
  task automatic instr(input int op, input int sf,
                       input int sm);
    int k;
    int guard;
    bit r;
    for (int i = 0; i < sf; i++) step(0, 0, -1);
    step(0, 1, -1);
    step(0, 1, op);
    k = 0;
    guard = 0;
    while (m_cur != 0 && guard < 40) begin
      r = 1'b1;
      if ((m_cur == 3 || m_cur == 5) && k < sm) begin
        r = 1'b0;
        k++;
      end
      step(0, r, -1);
      guard++;
    end
  endtask

  always @(negedge clk) begin
    exp_t  e;
    outs_t a;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{bus.pc_write, bus.pc_write_cond, bus.i_or_d,
            bus.mem_read, bus.mem_write, bus.ir_write,
            bus.mem_to_reg, bus.reg_dst, bus.reg_write,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.pc_source, bus.illegal_op, bus.mem_timeout};
      checks++;
      if (a !== e.o) begin
        errors++;
        $display("FAIL outputs cyc=%0d got=%h exp=%h",
                 cyc, a, e.o);
      end
      checks++;
      if (bus.state !== e.st) begin
        errors++;
        $display("FAIL state cyc=%0d got=%0d exp=%0d",
                 cyc, bus.state, e.st);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode = 6'b0;
    step(1, 0, -1);
    step(1, 1, -1);
    instr(6'b000000, 0, 0);
    instr(6'b100011, 0, 3);
    instr(6'b000100, 0, 0);
    instr(6'b111111, 0, 0);
    instr(6'b101011, 0, MT);
    instr(6'b100011, MT + 1, 0);
    instr(6'b000010, 2, 0);
    step(0, 1, -1);
    step(0, 1, 6'b000000);
    step(1, 1, -1);
    instr(6'b001000, 0, 0);
    instr(6'b101011, 0, 2);
    repeat (300) begin
      if ($urandom_range(0, 19) == 0)
        step(1, 1'($urandom_range(0, 1)), -1);
      instr(pick_op(), pick_stall(), pick_stall());
    end
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
